mux_n_pipe: RTL and testbench

- Parametrised N-input, WIDTH-bit selector with one registered output stage.
- Generalises the plain 2:1 datapath muxes in width and channel count.
- Adds a valid/ready handshake with a 2-entry skid buffer, so it can sit between pipeline stages (e.g. ID→EX operand/destination select) without combinational ready paths.
- Flags out-of-range select codes per beat.

---
 rtl/mux_n_pipe_pkg.sv | 13 +
 rtl/mux_n_comb.sv | 31 +++
 rtl/mux_n_pipe.sv | 116 +++++++++++
 tb/tb_mux_n_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_n_pipe_pkg.sv
// rtl/mux_n_pipe_pkg.sv - shared state encoding for the registered N:1 selector
package mux_n_pipe_pkg;

    localparam int STATE_W = 2;

    // EMPTY: main and skid free; ONE: main holds a beat; FULL: main and skid hold beats.
    typedef enum logic [STATE_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/mux_n_comb.sv
// rtl/mux_n_comb.sv - combinational N:1 indexed select with out-of-range flag
// Ports:
//   sel  - channel index
//   din  - flattened channels, channel k = din[k*WIDTH +: WIDTH]
//   data - selected channel, 0 when sel is out of range
//   err  - 1 when sel >= NUM_IN
module mux_n_comb #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] din,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    // Compare against each legal index rather than using sel as an index, so
    // codes beyond NUM_IN-1 never address past the end of din.
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                data = din[k*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// rtl/mux_n_pipe.sv - N-input selector with valid/ready handshake and 2-entry skid
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - upstream handshake; sel and din sampled on accept
//   out_valid/out_ready - downstream handshake
//   dout, dout_err      - selected beat and its out-of-range flag
module mux_n_pipe
    import mux_n_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] din,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        dout,
    output logic                    dout_err
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_err_q, main_err_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q, skid_err_d;

    logic accept;
    logic consume;

    mux_n_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_sel (
        .sel  (sel),
        .din  (din),
        .data (sel_data),
        .err  (sel_err)
    );

    // Ready comes only from registered state, so out_ready never reaches
    // in_ready combinationally; the skid entry absorbs the one-cycle lag.
    assign in_ready  = (state_q != ST_FULL) && !rst;
    assign out_valid = (state_q != ST_EMPTY);
    assign dout      = main_data_q;
    assign dout_err  = main_err_q;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_data_d = sel_data;
                    main_err_d  = sel_err;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    main_data_d = sel_data;
                    main_err_d  = sel_err;
                end else if (accept) begin
                    // Main is still being presented downstream; park the new beat.
                    skid_data_d = sel_data;
                    skid_err_d  = sel_err;
                    state_d     = ST_FULL;
                end else if (consume) begin
                    // dout keeps its last value while out_valid drops.
                    state_d     = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    main_data_d = skid_data_q;
                    main_err_d  = skid_err_q;
                    state_d     = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb/tb_mux_n_pipe.sv - scoreboard bench for mux_n_pipe over four parameter sets
module tb_mux_n_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut0: WIDTH=32 NUM_IN=4 SEL_W=2
    logic         iv0 = 1'b0, ir0, ov0, or0 = 1'b0, oe0;
    logic [1:0]   sl0 = '0;
    logic [127:0] dn0 = '0;
    logic [31:0]  dq0;
    // dut1: WIDTH=32 NUM_IN=3 SEL_W=2
    logic         iv1 = 1'b0, ir1, ov1, or1 = 1'b0, oe1;
    logic [1:0]   sl1 = '0;
    logic [95:0]  dn1 = '0;
    logic [31:0]  dq1;
    // dut2: WIDTH=5 NUM_IN=2 SEL_W=1
    logic         iv2 = 1'b0, ir2, ov2, or2 = 1'b0, oe2;
    logic [0:0]   sl2 = '0;
    logic [9:0]   dn2 = '0;
    logic [4:0]   dq2;
    // dut3: WIDTH=32 NUM_IN=16 SEL_W=4
    logic         iv3 = 1'b0, ir3, ov3, or3 = 1'b0, oe3;
    logic [3:0]   sl3 = '0;
    logic [511:0] dn3 = '0;
    logic [31:0]  dq3;

    mux_n_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .sel(sl0), .din(dn0),
        .out_valid(ov0), .out_ready(or0), .dout(dq0), .dout_err(oe0));
    mux_n_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .sel(sl1), .din(dn1),
        .out_valid(ov1), .out_ready(or1), .dout(dq1), .dout_err(oe1));
    mux_n_pipe #(.WIDTH(5), .NUM_IN(2), .SEL_W(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .sel(sl2), .din(dn2),
        .out_valid(ov2), .out_ready(or2), .dout(dq2), .dout_err(oe2));
    mux_n_pipe #(.WIDTH(32), .NUM_IN(16), .SEL_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .sel(sl3), .din(dn3),
        .out_valid(ov3), .out_ready(or3), .dout(dq3), .dout_err(oe3));

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q [4][$];
    logic        hold   [4];
    logic [31:0] hold_d [4];
    logic        hold_e [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: stability while stalled, then pop-and-compare on each consume.
    task automatic mon(input int id, input logic v, input logic r,
                       input logic [31:0] d, input logic e);
        exp_t x;
        if (hold[id]) begin
            chk($sformatf("stall_valid[%0d]", id), 32'(v), 32'd1);
            chk($sformatf("stall_data[%0d]", id), d, hold_d[id]);
            chk($sformatf("stall_err[%0d]", id), 32'(e), 32'(hold_e[id]));
        end
        if (v && r) begin
            if (exp_q[id].size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_extra[%0d]: got beat 0x%08h, required no beat", id, d);
            end else begin
                x = exp_q[id].pop_front();
                chk($sformatf("sb_data[%0d]", id), d, x.data);
                chk($sformatf("sb_err[%0d]", id), 32'(e), 32'(x.err));
            end
        end
        hold[id]   = v && !r;
        hold_d[id] = d;
        hold_e[id] = e;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hold[i] = 1'b0;
        end else begin
            mon(0, ov0, or0, dq0, oe0);
            mon(1, ov1, or1, dq1, oe1);
            mon(2, ov2, or2, {27'b0, dq2}, oe2);
            mon(3, ov3, or3, dq3, oe3);
        end
    end

    task automatic drive(input int id, input logic v, input logic [3:0] s, input logic [511:0] d);
        case (id)
            0: begin iv0 = v; sl0 = s[1:0]; dn0 = d[127:0]; end
            1: begin iv1 = v; sl1 = s[1:0]; dn1 = d[95:0];  end
            2: begin iv2 = v; sl2 = s[0:0]; dn2 = d[9:0];   end
            default: begin iv3 = v; sl3 = s; dn3 = d; end
        endcase
    endtask

    task automatic set_ordy(input int id, input logic r);
        case (id)
            0: or0 = r;
            1: or1 = r;
            2: or2 = r;
            default: or3 = r;
        endcase
    endtask

    function automatic logic rdy(input int id);
        case (id)
            0: return ir0;
            1: return ir1;
            2: return ir2;
            default: return ir3;
        endcase
    endfunction

    // One cycle of stimulus; an accepted beat has its expected result queued.
    task automatic step(input int id, input logic v, input logic [3:0] s, input logic [511:0] d,
                        input logic [31:0] ed, input logic ee, output logic took);
        exp_t x;
        drive(id, v, s, d);
        took = v && rdy(id);
        if (took) begin
            x.data = ed;
            x.err  = ee;
            exp_q[id].push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic exp_t model(input int nin, input int w, input logic [3:0] s, input logic [511:0] d);
        exp_t        x;
        logic [511:0] t;
        if (int'(s) < nin) begin
            t      = d >> (int'(s) * w);
            x.data = t[31:0] & ((32'h1 << w) - 32'h1);
            x.err  = 1'b0;
        end else begin
            x.data = '0;
            x.err  = 1'b1;
        end
        return x;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic         took;
        logic [511:0] d;
        logic [3:0]   s;
        exp_t         x;

        // Reset state
        #2;
        chk("rst_in_ready", 32'(ir0), 32'd0);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_dout", dq0, 32'd0);
        chk("rst_dout_err", 32'(oe0), 32'd0);
        cycles(2);
        #2 rst = 1'b0;
        cycles(1);
        chk("post_rst_in_ready", 32'(ir0), 32'd1);

        // Streaming, 1-cycle latency
        set_ordy(0, 1'b1);
        d = {384'b0, 32'h13, 32'h12, 32'h11, 32'h10};
        step(0, 1'b1, 4'd0, d, 32'h10, 1'b0, took);
        chk("stream_latency_valid", 32'(ov0), 32'd1);
        chk("stream_latency_dout", dq0, 32'h10);
        step(0, 1'b1, 4'd1, d, 32'h11, 1'b0, took);
        step(0, 1'b1, 4'd2, d, 32'h12, 1'b0, took);
        step(0, 1'b1, 4'd3, d, 32'h13, 1'b0, took);
        step(0, 1'b0, 4'd0, '0, 32'h0, 1'b0, took);
        chk("stream_drained_valid", 32'(ov0), 32'd0);
        chk("stream_sb_empty", 32'(exp_q[0].size()), 32'd0);

        // Backpressure into FULL, third push ignored
        set_ordy(0, 1'b0);
        d = {384'b0, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001, 32'h0};
        step(0, 1'b1, 4'd1, d, 32'hAAAA_0001, 1'b0, took);
        step(0, 1'b1, 4'd2, d, 32'hBBBB_0002, 1'b0, took);
        chk("bp_full_in_ready", 32'(ir0), 32'd0);
        chk("bp_hold_dout", dq0, 32'hAAAA_0001);
        step(0, 1'b1, 4'd3, d, 32'hCCCC_0003, 1'b0, took);
        chk("bp_third_ignored", 32'(took), 32'd0);
        drive(0, 1'b0, 4'd0, '0);
        set_ordy(0, 1'b1);
        cycles(3);
        chk("bp_drained_valid", 32'(ov0), 32'd0);
        chk("bp_sb_empty", 32'(exp_q[0].size()), 32'd0);

        // Reset while FULL
        set_ordy(0, 1'b0);
        step(0, 1'b1, 4'd1, d, 32'hAAAA_0001, 1'b0, took);
        step(0, 1'b1, 4'd2, d, 32'hBBBB_0002, 1'b0, took);
        drive(0, 1'b0, 4'd0, '0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(ov0), 32'd0);
        chk("midrst_dout", dq0, 32'd0);
        chk("midrst_in_ready", 32'(ir0), 32'd0);
        exp_q[0].delete();
        @(posedge clk);
        #3 rst = 1'b0;
        cycles(1);
        chk("midrst_release_in_ready", 32'(ir0), 32'd1);
        set_ordy(0, 1'b1);
        step(0, 1'b1, 4'd3, d, 32'hCCCC_0003, 1'b0, took);
        chk("midrst_first_beat", dq0, 32'hCCCC_0003);
        step(0, 1'b0, 4'd0, '0, 32'h0, 1'b0, took);

        // Out-of-range select on NUM_IN=3
        set_ordy(1, 1'b1);
        d = {416'b0, 32'h2222_2222, 32'h1111_1111, 32'h0000_5A5A};
        step(1, 1'b1, 4'd3, d, 32'h0, 1'b1, took);
        chk("oor_err", 32'(oe1), 32'd1);
        chk("oor_dout", dq1, 32'd0);
        step(1, 1'b1, 4'd0, d, 32'h0000_5A5A, 1'b0, took);
        chk("oor_next_err", 32'(oe1), 32'd0);
        step(1, 1'b0, 4'd0, '0, 32'h0, 1'b0, took);
        chk("oor_sb_empty", 32'(exp_q[1].size()), 32'd0);

        // Toggling out_ready with continuous in_valid
        for (int i = 0; i < 8; i++) begin
            d = '0;
            for (int k = 0; k < 4; k++) d[k*32 +: 32] = 32'h5000_0000 + 32'(i * 16 + k);
            set_ordy(0, (i % 2) == 0);
            s = 4'(i % 4);
            step(0, 1'b1, s, d, 32'h5000_0000 + 32'(i * 16 + i % 4), 1'b0, took);
        end
        drive(0, 1'b0, 4'd0, '0);
        set_ordy(0, 1'b1);
        cycles(3);
        chk("toggle_sb_empty", 32'(exp_q[0].size()), 32'd0);

        // Random sweeps at full select range (dout_err must stay 0)
        for (int id = 2; id < 4; id++) begin
            for (int c = 0; c < 300; c++) begin
                for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
                s = (id == 2) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
                x = (id == 2) ? model(2, 5, s, d) : model(16, 32, s, d);
                set_ordy(id, $urandom_range(0, 2) != 0);
                step(id, $urandom_range(0, 3) != 0, s, d, x.data, x.err, took);
            end
            drive(id, 1'b0, 4'd0, '0);
            set_ordy(id, 1'b1);
            cycles(3);
            chk($sformatf("sweep_sb_empty[%0d]", id), 32'(exp_q[id].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
